// File: rtl/img_framer_pkg.sv
// Shared types and elaboration-time helpers for the image record framer.
// Holds the framer state encoding, byte swap and pad-length derivation.
package img_framer_pkg;

    typedef enum logic [2:0] {
        Idle,
        Header,
        Pixels,
        Cksum0,
        Cksum1,
        Pad
    } frameState_t;

    function automatic logic [15:0] bswap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    // Words needed to round header + pixels + checksum up to a block multiple.
    function automatic int padCountCalc(input int hdrCount, input int width,
                                        input int height, input int cksumEn,
                                        input int padMultiple);
        int total;
        int rem;
        total = hdrCount + width * height + 2 * cksumEn;
        rem   = total % padMultiple;
        return (rem == 0) ? 0 : padMultiple - rem;
    endfunction

    function automatic int clog2Min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fletcher32_accum.sv
// Fletcher-32 running sums over 16-bit words, both reduced modulo 65535.
// A sum landing exactly on 65535 folds to 0.
module fletcher32_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] dout
);

    logic [15:0] s1Reg, s2Reg;
    logic [15:0] s1Next, s2Next;

    function automatic logic [15:0] addMod(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 17'd65535) begin
            sum = sum - 17'd65535;
        end
        return sum[15:0];
    endfunction

    assign s1Next = addMod(s1Reg, din);
    assign s2Next = addMod(s2Reg, s1Next);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1Reg <= '0;
            s2Reg <= '0;
        end else if (en) begin
            s1Reg <= s1Next;
            s2Reg <= s2Next;
        end
    end

    assign dout = {s2Reg, s1Reg};

endmodule

// File: rtl/img_stream_framer.sv
// Frames a pixel stream into header, pixels, Fletcher-32 checksum and zero pad.
// Header and pixel words pass through combinationally; only control state is registered.
module img_stream_framer
    import img_framer_pkg::*;
#(
    parameter int HeaderWordCount = 5,
    parameter int ImageWidth      = 2304,
    parameter int ImageHeight     = 1296,
    parameter int ChecksumEn      = 1,
    parameter int PadMultiple     = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic [$clog2((HeaderWordCount > 2) ? HeaderWordCount : 2)-1:0] hdr_idx,
    input  logic [15:0] hdr_word,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int HdrIdxW  = $clog2((HeaderWordCount > 2) ? HeaderWordCount : 2);
    localparam int PixTotal = ImageWidth * ImageHeight;
    localparam int PixCntW  = $clog2(PixTotal + 1);
    localparam int PadTotal = padCountCalc(HeaderWordCount, ImageWidth, ImageHeight,
                                           (ChecksumEn != 0) ? 1 : 0, PadMultiple);
    localparam int PadCntW  = clog2Min1(PadMultiple);

    localparam frameState_t AfterCksum  = (PadTotal != 0) ? Pad : Idle;
    localparam frameState_t AfterPixels = (ChecksumEn != 0) ? Cksum0 : AfterCksum;
    localparam frameState_t AfterStart  = (HeaderWordCount > 0) ? Header : Pixels;

    frameState_t        stateReg, stateNext;
    logic [HdrIdxW-1:0] hdrIdxReg, hdrIdxNext;
    logic [PixCntW-1:0] pixCntReg, pixCntNext;
    logic [PadCntW-1:0] padCntReg, padCntNext;
    logic               busyReg, doneReg;

    logic        startAccept;
    logic        accumEn;
    logic        finalXfer;
    logic [31:0] cksum;

    assign startAccept = (stateReg == Idle) && start;
    assign finalXfer   = out_valid && out_ready && out_last;

    always_comb begin
        stateNext  = stateReg;
        hdrIdxNext = hdrIdxReg;
        pixCntNext = pixCntReg;
        padCntNext = padCntReg;
        out_valid  = 1'b0;
        in_ready   = 1'b0;
        out_data   = 16'h0000;
        out_last   = 1'b0;
        accumEn    = 1'b0;

        case (stateReg)
            Idle: begin
                hdrIdxNext = '0;
                if (start) begin
                    stateNext = AfterStart;
                end
            end
            Header: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
                if (out_ready) begin
                    accumEn = 1'b1;
                    if (hdrIdxReg == HdrIdxW'(HeaderWordCount - 1)) begin
                        hdrIdxNext = '0;
                        stateNext  = Pixels;
                    end else begin
                        hdrIdxNext = hdrIdxReg + 1'b1;
                    end
                end
            end
            Pixels: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                out_data  = in_data;
                out_last  = (pixCntReg == PixCntW'(PixTotal - 1)) &&
                            (ChecksumEn == 0) && (PadTotal == 0);
                if (in_valid && out_ready) begin
                    accumEn = 1'b1;
                    if (pixCntReg == PixCntW'(PixTotal - 1)) begin
                        pixCntNext = '0;
                        stateNext  = AfterPixels;
                    end else begin
                        pixCntNext = pixCntReg + 1'b1;
                    end
                end
            end
            Cksum0: begin
                out_valid = 1'b1;
                out_data  = {cksum[7:0], cksum[15:8]};
                if (out_ready) begin
                    stateNext = Cksum1;
                end
            end
            Cksum1: begin
                out_valid = 1'b1;
                out_data  = {cksum[23:16], cksum[31:24]};
                out_last  = (PadTotal == 0);
                if (out_ready) begin
                    stateNext = AfterCksum;
                end
            end
            Pad: begin
                out_valid = 1'b1;
                out_last  = (padCntReg == PadCntW'(PadTotal - 1));
                if (out_ready) begin
                    if (padCntReg == PadCntW'(PadTotal - 1)) begin
                        padCntNext = '0;
                        stateNext  = Idle;
                    end else begin
                        padCntNext = padCntReg + 1'b1;
                    end
                end
            end
            default: begin
                stateNext = Idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= Idle;
            hdrIdxReg <= '0;
            pixCntReg <= '0;
            padCntReg <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            hdrIdxReg <= hdrIdxNext;
            pixCntReg <= pixCntNext;
            padCntReg <= padCntNext;
            doneReg   <= finalXfer;
            if (startAccept) begin
                busyReg <= 1'b1;
            end else if (finalXfer) begin
                busyReg <= 1'b0;
            end
        end
    end

    // The checksum is taken over little-endian values, hence the swap on entry.
    fletcher32_accum uAccum (
        .clk  (clk),
        .rst  (rst),
        .clr  (startAccept),
        .en   (accumEn),
        .din  (bswap16(out_data)),
        .dout (cksum)
    );

    assign hdr_idx = hdrIdxReg;
    assign busy    = busyReg;
    assign done    = doneReg;

endmodule

// File: tb/tb_img_stream_framer.sv
// Directed bench: three framer configurations driven from one linear sequence.
// Expected words are hand-computed constants for each configuration.
module tb_img_stream_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: hdr=0 W=H=1 pad 4; 1: hdr=2 W=4 H=2 pad 16; 2: same without checksum or pad.
    logic        start    [3];
    logic        hdrIdx   [3];
    logic [15:0] hdrWord  [3];
    logic        inValid  [3];
    logic        inReady  [3];
    logic [15:0] inData   [3];
    logic        outValid [3];
    logic        outReady [3];
    logic [15:0] outData  [3];
    logic        outLast  [3];
    logic        busy     [3];
    logic        done     [3];

    assign hdrWord[0] = 16'h0000;
    assign hdrWord[1] = (hdrIdx[1] == 1'b0) ? 16'h1234 : 16'hABCD;
    assign hdrWord[2] = (hdrIdx[2] == 1'b0) ? 16'h1234 : 16'hABCD;

    img_stream_framer #(.HeaderWordCount(0), .ImageWidth(1), .ImageHeight(1),
                        .ChecksumEn(1), .PadMultiple(4)) dutA (
        .clk(clk), .rst(rst), .start(start[0]), .hdr_idx(hdrIdx[0]), .hdr_word(hdrWord[0]),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
        .out_last(outLast[0]), .busy(busy[0]), .done(done[0]));

    img_stream_framer #(.HeaderWordCount(2), .ImageWidth(4), .ImageHeight(2),
                        .ChecksumEn(1), .PadMultiple(16)) dutB (
        .clk(clk), .rst(rst), .start(start[1]), .hdr_idx(hdrIdx[1]), .hdr_word(hdrWord[1]),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
        .out_last(outLast[1]), .busy(busy[1]), .done(done[1]));

    img_stream_framer #(.HeaderWordCount(2), .ImageWidth(4), .ImageHeight(2),
                        .ChecksumEn(0), .PadMultiple(1)) dutC (
        .clk(clk), .rst(rst), .start(start[2]), .hdr_idx(hdrIdx[2]), .hdr_word(hdrWord[2]),
        .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
        .out_last(outLast[2]), .busy(busy[2]), .done(done[2]));

    int tests  = 0;
    int failed = 0;

    logic [15:0] pixQ[$];
    logic [15:0] expQ[$];
    logic [15:0] gotQ[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input int d, input string tag);
        @(negedge clk);
        check($sformatf("%s out_valid", tag), 32'(outValid[d]), 32'd0);
        check($sformatf("%s in_ready", tag),  32'(inReady[d]),  32'd0);
        check($sformatf("%s out_last", tag),  32'(outLast[d]),  32'd0);
        check($sformatf("%s out_data", tag),  32'(outData[d]),  32'd0);
        check($sformatf("%s busy", tag),      32'(busy[d]),     32'd0);
        check($sformatf("%s done", tag),      32'(done[d]),     32'd0);
        check($sformatf("%s hdr_idx", tag),   32'(hdrIdx[d]),   32'd0);
    endtask

    // Starts a record on DUT d, feeds pixQ, collects output words and checks them against expQ.
    task automatic runRecord(input int d, input bit throttle, input string tag);
        int          pIdx;
        bit          offered;
        bit          stalled;
        bit          finished;
        logic [15:0] holdData;
        logic        holdLast;
        pIdx     = 0;
        offered  = 1'b0;
        stalled  = 1'b0;
        finished = 1'b0;
        holdData = 16'h0;
        holdLast = 1'b0;
        gotQ.delete();

        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        check($sformatf("%s busy after start", tag), 32'(busy[d]), 32'd1);

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (!offered) begin
                if (pIdx < pixQ.size() && (!throttle || $urandom_range(0, 2) != 0)) begin
                    inValid[d] = 1'b1;
                    inData[d]  = pixQ[pIdx];
                end else begin
                    inValid[d] = 1'b0;
                    inData[d]  = 16'h0000;
                end
            end
            outReady[d] = !throttle || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) begin
                check($sformatf("%s stall valid", tag), 32'(outValid[d]), 32'd1);
                check($sformatf("%s stall data", tag),  32'(outData[d]),  32'(holdData));
                check($sformatf("%s stall last", tag),  32'(outLast[d]),  32'(holdLast));
            end
            stalled  = outValid[d] && !outReady[d];
            holdData = outData[d];
            holdLast = outLast[d];
            if (inValid[d] && inReady[d]) begin
                pIdx++;
                offered = 1'b0;
            end else begin
                offered = inValid[d];
            end
            if (outValid[d] && outReady[d]) begin
                gotQ.push_back(outData[d]);
                if (outLast[d]) finished = 1'b1;
            end
            @(posedge clk); #1;
        end
        inValid[d]  = 1'b0;
        outReady[d] = 1'b1;

        check($sformatf("%s record ended", tag), 32'(finished), 32'd1);
        check($sformatf("%s word count", tag), 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < gotQ.size()) begin
                check($sformatf("%s word %0d", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
            end
        end
        @(negedge clk);
        check($sformatf("%s done pulse", tag), 32'(done[d]), 32'd1);
        check($sformatf("%s busy cleared", tag), 32'(busy[d]), 32'd0);
        @(negedge clk);
        check($sformatf("%s done single", tag), 32'(done[d]), 32'd0);
        $display("[TB] record %s: %0d words collected", tag, gotQ.size());
        @(posedge clk); #1;
    endtask

    task automatic loadRecordB();
        pixQ.delete();
        expQ = {16'h1234, 16'hABCD};
        for (int i = 1; i <= 8; i++) begin
            pixQ.push_back(16'(i));
            expQ.push_back(16'(i));
        end
        expQ.push_back(16'hBE25);
        expQ.push_back(16'hC0BB);
        for (int i = 0; i < 4; i++) expQ.push_back(16'h0000);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start[d]    = 1'b0;
            inValid[d]  = 1'b0;
            inData[d]   = 16'h0000;
            outReady[d] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) checkIdleOutputs(d, $sformatf("reset dut%0d", d));
        rst = 1'b0;
        @(posedge clk); #1;

        pixQ = {16'h0100};
        expQ = {16'h0100, 16'h0100, 16'h0100, 16'h0000};
        runRecord(0, 1'b0, "A pix0100");

        pixQ = {16'hFFFF};
        expQ = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        runRecord(0, 1'b0, "A pixFFFF");

        loadRecordB();
        runRecord(1, 1'b0, "B steady");

        loadRecordB();
        runRecord(1, 1'b1, "B throttled");

        pixQ.delete();
        expQ = {16'h1234, 16'hABCD};
        for (int i = 1; i <= 8; i++) begin
            pixQ.push_back(16'(i));
            expQ.push_back(16'(i));
        end
        runRecord(2, 1'b0, "C nocksum");

        // Abort B in the middle of its pixel phase.
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1]   = 1'b0;
        inValid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            inData[1] = 16'(k + 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("abort in pixels in_ready", 32'(inReady[1]), 32'd1);
        check("abort in pixels busy", 32'(busy[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkIdleOutputs(1, "abort");
        inValid[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("abort no done %0d", k), 32'(done[1]), 32'd0);
        end
        @(posedge clk); #1;

        loadRecordB();
        runRecord(1, 1'b0, "B after abort");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
